thread_regfile: RTL and testbench

Per-thread register file sitting directly upstream and downstream of the thread ALU. It supplies the rs/rt operands that the ALU consumes in EXECUTE, and writes back the ALU result, LSU load data or a decoded immediate in UPDATE. Each thread in each core has one instance, alongside its ALU and LSU. R13–R15 are read-only special registers: block index, block dimension and thread index.

---
 rtl/states_pkg.sv | 21 ++
 rtl/thread_regfile.sv | 61 ++++++
 tb/tb_thread_regfile.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/states_pkg.sv
// states_pkg: shared core pipeline state encoding and thread register file constants.
package states_pkg;
  typedef enum logic [2:0] {
    IDLE    = 3'b000,
    FETCH   = 3'b001,
    DECODE  = 3'b010,
    REQUEST = 3'b011,
    WAIT    = 3'b100,
    EXECUTE = 3'b101,
    UPDATE  = 3'b110,
    DONE    = 3'b111
  } core_state_t;
  typedef enum logic [1:0] {
    ALU      = 2'b00,
    MEMORY   = 2'b01,
    CONSTANT = 2'b10
  } reg_input_mux_t;
  localparam logic [3:0] REG_BLOCK_IDX  = 4'd13;
  localparam logic [3:0] REG_BLOCK_DIM  = 4'd14;
  localparam logic [3:0] REG_THREAD_IDX = 4'd15;
endpackage

// File: rtl/thread_regfile.sv
// thread_regfile: per-thread 16-entry register file feeding ALU/LSU operands and taking write-back.
module thread_regfile
  import states_pkg::*;
#(
  parameter int DATA_BITS         = 8,
  parameter int THREADS_PER_BLOCK = 4,
  parameter int THREAD_ID         = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [DATA_BITS-1:0] block_id,
  input  core_state_t          core_state,
  input  logic [3:0]           decoded_rd_address,
  input  logic [3:0]           decoded_rs_address,
  input  logic [3:0]           decoded_rt_address,
  input  logic                 decoded_reg_write_enable,
  input  logic [1:0]           decoded_reg_input_mux,
  input  logic [DATA_BITS-1:0] decoded_immediate,
  input  logic [DATA_BITS-1:0] alu_out,
  input  logic [DATA_BITS-1:0] lsu_out,
  output logic [DATA_BITS-1:0] rs,
  output logic [DATA_BITS-1:0] rt
);
  logic [DATA_BITS-1:0] r_regs [16];
  logic [DATA_BITS-1:0] r_rs, r_rt;
  logic [DATA_BITS-1:0] w_wdata;
  logic                 w_src_ok, w_we;
  always_comb begin
    w_wdata  = '0;
    w_src_ok = 1'b1;
    case (reg_input_mux_t'(decoded_reg_input_mux))
      ALU:      w_wdata = alu_out;
      MEMORY:   w_wdata = lsu_out;
      CONSTANT: w_wdata = decoded_immediate;
      default:  w_src_ok = 1'b0;
    endcase
    // special registers R13-R15 are never writable from an instruction
    w_we = enable && core_state == UPDATE && decoded_reg_write_enable && w_src_ok &&
           decoded_rd_address < REG_BLOCK_IDX;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 13; i++) r_regs[i] <= '0;
      r_regs[REG_BLOCK_IDX]  <= '0;
      r_regs[REG_BLOCK_DIM]  <= DATA_BITS'(THREADS_PER_BLOCK);
      r_regs[REG_THREAD_IDX] <= DATA_BITS'(THREAD_ID);
      r_rs <= '0;
      r_rt <= '0;
    end else if (enable) begin
      r_regs[REG_BLOCK_IDX] <= block_id;
      if (core_state == REQUEST) begin
        r_rs <= r_regs[decoded_rs_address];
        r_rt <= r_regs[decoded_rt_address];
      end
      if (w_we) r_regs[decoded_rd_address] <= w_wdata;
    end
  end
  assign rs = r_rs;
  assign rt = r_rt;
endmodule

// File: tb/tb_thread_regfile.sv
// tb_thread_regfile: directed checks of reads, write-back sources, protection, enable and reset.
module tb_thread_regfile;
  import states_pkg::*;
  logic        clk = 1'b0;
  logic        reset, enable;
  logic [7:0]  block_id, decoded_immediate, alu_out, lsu_out, rs, rt;
  core_state_t core_state;
  logic [3:0]  decoded_rd_address, decoded_rs_address, decoded_rt_address;
  logic        decoded_reg_write_enable;
  logic [1:0]  decoded_reg_input_mux;
  int checks = 0, failures = 0;

  thread_regfile #(.DATA_BITS(8), .THREADS_PER_BLOCK(4), .THREAD_ID(2)) dut (
    .clk(clk), .reset(reset), .enable(enable), .block_id(block_id), .core_state(core_state),
    .decoded_rd_address(decoded_rd_address), .decoded_rs_address(decoded_rs_address),
    .decoded_rt_address(decoded_rt_address), .decoded_reg_write_enable(decoded_reg_write_enable),
    .decoded_reg_input_mux(decoded_reg_input_mux), .decoded_immediate(decoded_immediate),
    .alu_out(alu_out), .lsu_out(lsu_out), .rs(rs), .rt(rt));

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_read(input logic [3:0] a, input logic [3:0] b);
    core_state = REQUEST;
    decoded_rs_address = a;
    decoded_rt_address = b;
    step();
    core_state = IDLE;
  endtask

  task automatic do_write(input logic we, input logic [3:0] rd, input logic [1:0] mux, input logic [7:0] v);
    core_state = UPDATE;
    decoded_reg_write_enable = we;
    decoded_rd_address = rd;
    decoded_reg_input_mux = mux;
    decoded_immediate = (mux == 2'b10) ? v : 8'hC3;
    alu_out = (mux == 2'b00) ? v : 8'h3C;
    lsu_out = (mux == 2'b01) ? v : 8'h5A;
    if (mux == 2'b11) begin decoded_immediate = v; alu_out = v; lsu_out = v; end
    step();
    core_state = IDLE;
    decoded_reg_write_enable = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    checks++; if (rs !== 8'h00) begin failures++; $display("FAIL reset_rs got=%h exp=%h", rs, 8'h00); end
    checks++; if (rt !== 8'h00) begin failures++; $display("FAIL reset_rt got=%h exp=%h", rt, 8'h00); end
    do_read(4'd14, 4'd15);
    checks++; if (rs !== 8'h04) begin failures++; $display("FAIL reset_r14 got=%h exp=%h", rs, 8'h04); end
    checks++; if (rt !== 8'h02) begin failures++; $display("FAIL reset_r15 got=%h exp=%h", rt, 8'h02); end
  endtask

  task automatic test_const();
    do_write(1'b1, 4'd3, 2'b10, 8'h2A);
    do_read(4'd3, 4'd0);
    checks++; if (rs !== 8'h2A) begin failures++; $display("FAIL const_r3 got=%h exp=%h", rs, 8'h2A); end
    checks++; if (rt !== 8'h00) begin failures++; $display("FAIL const_r0 got=%h exp=%h", rt, 8'h00); end
  endtask

  task automatic test_alu_lsu();
    do_write(1'b1, 4'd5, 2'b00, 8'h07);
    do_write(1'b1, 4'd6, 2'b01, 8'hF0);
    do_read(4'd5, 4'd6);
    checks++; if (rs !== 8'h07) begin failures++; $display("FAIL alu_r5 got=%h exp=%h", rs, 8'h07); end
    checks++; if (rt !== 8'hF0) begin failures++; $display("FAIL lsu_r6 got=%h exp=%h", rt, 8'hF0); end
  endtask

  task automatic test_protect();
    do_write(1'b1, 4'd14, 2'b10, 8'h99);
    do_write(1'b1, 4'd15, 2'b00, 8'h99);
    do_read(4'd14, 4'd15);
    checks++; if (rs !== 8'h04) begin failures++; $display("FAIL protect_r14 got=%h exp=%h", rs, 8'h04); end
    checks++; if (rt !== 8'h02) begin failures++; $display("FAIL protect_r15 got=%h exp=%h", rt, 8'h02); end
    do_write(1'b1, 4'd2, 2'b11, 8'h77);
    do_write(1'b0, 4'd7, 2'b10, 8'h66);
    do_read(4'd2, 4'd7);
    checks++; if (rs !== 8'h00) begin failures++; $display("FAIL mux11_r2 got=%h exp=%h", rs, 8'h00); end
    checks++; if (rt !== 8'h00) begin failures++; $display("FAIL we0_r7 got=%h exp=%h", rt, 8'h00); end
    core_state = EXECUTE;
    decoded_reg_write_enable = 1'b1;
    decoded_rd_address = 4'd8;
    decoded_reg_input_mux = 2'b10;
    decoded_immediate = 8'h44;
    decoded_rs_address = 4'd3;
    decoded_rt_address = 4'd5;
    step();
    decoded_reg_write_enable = 1'b0;
    checks++; if (rs !== 8'h00) begin failures++; $display("FAIL hold_rs got=%h exp=%h", rs, 8'h00); end
    checks++; if (rt !== 8'h00) begin failures++; $display("FAIL hold_rt got=%h exp=%h", rt, 8'h00); end
    do_read(4'd8, 4'd3);
    checks++; if (rs !== 8'h00) begin failures++; $display("FAIL execute_nowrite_r8 got=%h exp=%h", rs, 8'h00); end
    checks++; if (rt !== 8'h2A) begin failures++; $display("FAIL r3_kept got=%h exp=%h", rt, 8'h2A); end
  endtask

  task automatic test_block_id();
    block_id = 8'h05;
    step();
    enable = 1'b0;
    block_id = 8'h09;
    do_read(4'd5, 4'd6);
    do_write(1'b1, 4'd5, 2'b10, 8'hEE);
    checks++; if (rs !== 8'h00) begin failures++; $display("FAIL disabled_rs got=%h exp=%h", rs, 8'h00); end
    enable = 1'b1;
    do_read(4'd13, 4'd5);
    checks++; if (rs !== 8'h05) begin failures++; $display("FAIL r13_held got=%h exp=%h", rs, 8'h05); end
    checks++; if (rt !== 8'h07) begin failures++; $display("FAIL disabled_nowrite_r5 got=%h exp=%h", rt, 8'h07); end
    do_read(4'd13, 4'd13);
    checks++; if (rs !== 8'h09) begin failures++; $display("FAIL r13_updated got=%h exp=%h", rs, 8'h09); end
  endtask

  task automatic test_reset_mid();
    do_write(1'b1, 4'd1, 2'b10, 8'h11);
    do_read(4'd1, 4'd1);
    checks++; if (rs !== 8'h11) begin failures++; $display("FAIL r1_set got=%h exp=%h", rs, 8'h11); end
    reset = 1'b1;
    do_write(1'b1, 4'd1, 2'b10, 8'h22);
    reset = 1'b0;
    checks++; if (rs !== 8'h00) begin failures++; $display("FAIL midreset_rs got=%h exp=%h", rs, 8'h00); end
    checks++; if (rt !== 8'h00) begin failures++; $display("FAIL midreset_rt got=%h exp=%h", rt, 8'h00); end
    do_read(4'd1, 4'd14);
    checks++; if (rs !== 8'h00) begin failures++; $display("FAIL midreset_r1 got=%h exp=%h", rs, 8'h00); end
    checks++; if (rt !== 8'h04) begin failures++; $display("FAIL midreset_r14 got=%h exp=%h", rt, 8'h04); end
    do_read(4'd15, 4'd3);
    checks++; if (rs !== 8'h02) begin failures++; $display("FAIL midreset_r15 got=%h exp=%h", rs, 8'h02); end
    checks++; if (rt !== 8'h00) begin failures++; $display("FAIL midreset_r3 got=%h exp=%h", rt, 8'h00); end
  endtask

  initial begin
    reset = 1'b1; enable = 1'b1; block_id = 8'h00; core_state = IDLE;
    decoded_rd_address = 4'd0; decoded_rs_address = 4'd0; decoded_rt_address = 4'd0;
    decoded_reg_write_enable = 1'b0; decoded_reg_input_mux = 2'b11;
    decoded_immediate = 8'h00; alu_out = 8'h00; lsu_out = 8'h00;
    test_reset();
    test_const();
    test_alu_lsu();
    test_protect();
    test_block_id();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
